// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with a show-ahead scancode FIFO.
// Rejected or timed-out frames raise a one-cycle frame_error; full-FIFO drops set sticky overflow.
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic       CLK_CPU,
    input  logic       resetn,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_error,
    output logic       overflow,
    input  logic       clear_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic             kb_clk_q;
    logic             fall;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_ok_q, parity_ok_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic             frame_error_q, frame_error_d;
    logic             timeout;
    logic             push;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             overflow_q;
    logic             full, pop, wr, overflow_set;

    assign fall    = kb_clk_q & ~keyboard_clock;
    // A falling edge on the same cycle as the limit still counts as progress.
    assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK_CPU) begin
        if (!resetn) begin
            state_q       <= StIdle;
            kb_clk_q      <= 1'b1;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_ok_q   <= 1'b0;
            to_cnt_q      <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kb_clk_q      <= keyboard_clock;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            parity_ok_q   <= parity_ok_d;
            to_cnt_q      <= to_cnt_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (fall && !keyboard_data) state_d = StData;
            StData:   if (fall && bit_idx_q == 3'd7) state_d = StParity;
            StParity: if (fall) state_d = StStop;
            StStop:   if (fall) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout) state_d = StIdle;
    end

    always_comb begin
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        parity_ok_d   = parity_ok_q;
        frame_error_d = 1'b0;
        push          = 1'b0;
        to_cnt_d      = (state_q == StIdle || fall) ? '0 : to_cnt_q + ToW'(1);
        unique case (state_q)
            StIdle:   if (fall && !keyboard_data) bit_idx_d = 3'd0;
            StData: begin
                if (fall) begin
                    shift_d   = {keyboard_data, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StParity: if (fall) parity_ok_d = ^{shift_q, keyboard_data};
            StStop: begin
                if (fall) begin
                    if (keyboard_data && parity_ok_q) push = 1'b1;
                    else frame_error_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (timeout) frame_error_d = 1'b1;
    end

    assign full         = (count_q == CntW'(FIFO_DEPTH));
    assign pop          = rd_en && rd_valid;
    assign wr           = push && (!full || pop);
    assign overflow_set = push && full && !pop;

    always_ff @(posedge CLK_CPU) begin
        if (wr) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge CLK_CPU) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (wr && !pop)      count_q <= count_q + CntW'(1);
            else if (!wr && pop) count_q <= count_q - CntW'(1);
            if (overflow_set)   overflow_q <= 1'b1;
            else if (clear_err) overflow_q <= 1'b0;
        end
    end

    assign rd_valid    = (count_q != '0);
    assign rd_data     = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, scancode buffer depth in bytes (power of 2, >= 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16000, CLK_CPU cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 16 MHz).
REQ-003 SHALL have port CLK_CPU, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port keyboard_clock, input, 1, PS/2 clock, already two-flop synchronized to CLK_CPU upstream.
REQ-006 SHALL have port keyboard_data, input, 1, PS/2 data, already two-flop synchronized to CLK_CPU upstream.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port rd_data, output, 8, scancode at FIFO head (show-ahead).
REQ-009 SHALL have port rd_valid, output, 1, high while FIFO is non-empty.
REQ-010 SHALL have port frame_error, output, 1, one-cycle pulse per rejected frame.
REQ-011 SHALL have port overflow, output, 1, sticky flag: scancode dropped because FIFO was full.
REQ-012 SHALL have port clear_err, input, 1, clears overflow.

Function
REQ-013 SHALL detect PS/2 clock falling edge as registered previous keyboard_clock = 1 and current = 0; previous register resets to 1.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP; all bit sampling on falling-edge cycles only.
REQ-015 IDLE: falling edge with keyboard_data = 0 -> DATA, bit index 0; falling edge with keyboard_data = 1 -> stay IDLE, no error.
REQ-016 DATA: shift in 8 bits LSB first; after bit index 7 -> PARITY.
REQ-017 PARITY: sample bit; frame parity SHALL be odd (XOR of 8 data bits and parity bit = 1); record result -> STOP.
REQ-018 STOP: sample bit; stop = 1 and parity good -> push byte into FIFO; otherwise pulse frame_error and discard; always -> IDLE.
REQ-019 Pushed byte SHALL be visible on rd_data/rd_valid the cycle after the stop-bit falling edge if FIFO was empty.
REQ-020 Timeout counter SHALL clear on every falling edge and in IDLE; when it reaches TIMEOUT_CYCLES-1 outside IDLE -> IDLE, partial frame discarded, frame_error pulsed.
REQ-021 rd_en with rd_valid = 1 SHALL pop the head; next entry (if any) appears the following cycle; rd_en with rd_valid = 0 ignored.
REQ-022 Push when FIFO full and no pop the same cycle: byte dropped, overflow set to 1, stays 1 until clear_err = 1 or reset.
REQ-023 Simultaneous push and pop when full: both SHALL occur, no overflow.
REQ-024 Simultaneous push and rd_en when empty: push only.
REQ-025 clear_err and overflow-set in same cycle: set wins.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1; ordering strictly FIFO.

Reset
REQ-027 resetn = 0 on a CLK_CPU edge SHALL force state IDLE, bit index 0, timeout 0, FIFO empty, rd_valid 0, rd_data 0x00, frame_error 0, overflow 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without frame_error; reception resumes at the next start bit after release.

Verification
REQ-029 Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> rd_valid = 1, rd_data = 0x1C one cycle after stop edge; rd_en pulse -> rd_valid = 0.
REQ-030 Frame 0x1C with parity 1 -> single-cycle frame_error, rd_valid stays 0.
REQ-031 Start + 3 data bits then keyboard_clock held high 16000 cycles -> frame_error pulse, IDLE; following frame 0xF0 (parity 1) received as 0xF0.
REQ-032 Five valid frames 0x01..0x05, no reads, FIFO_DEPTH 4 -> overflow = 1 after fifth; reads return 0x01..0x04; clear_err -> overflow = 0.
REQ-033 resetn low during data bit 4 then valid frame 0x5A (parity 1) -> no frame_error, rd_data = 0x5A.
REQ-034 FIFO full, rd_en asserted on the push cycle of frame 0x29 -> overflow stays 0, 0x29 becomes last entry.
